morse_symbol_decoder: RTL and testbench
=======================================

// Module: morse_symbol_decoder
// PURPOSE
//  Consumes the 1-bit serial key stream produced by the shift-register receive path.
//  Measures the high (mark) and low (space) run lengths in sample ticks.
//  Classifies each mark as dot or dash and accumulates the elements of one letter.
//  Emits the letter as a code word plus element count, and flags word gaps for the
//  downstream character lookup stage.
// PARAMETERS
//  CNT_W      8   run-length counter width; counters saturate at 2^CNT_W-1
//  DOT_MAX    2   mark of <= DOT_MAX ticks is a dot, longer is a dash
//  LETTER_GAP 5   space of >= LETTER_GAP ticks ends the letter
//  WORD_GAP   10  space of >= WORD_GAP ticks (from mark end) ends the word
//  Legal: 1 <= DOT_MAX < LETTER_GAP < WORD_GAP <= 2^CNT_W-1 (elaboration-time check)
// PORTS
//  CLK          in   1  system clock, all logic on rising edge
//  RST          in   1  asynchronous, active-high reset
//  tick         in   1  sample enable; run counters/FSM advance only when tick=1
//  key_in       in   1  serial key level (1=mark), may be asynchronous
//  code_out     out  5  element i at bit i, first element bit0; 1=dash, 0=dot
//  code_len     out  3  number of valid elements in code_out (1..5)
//  code_valid   out  1  one-CLK pulse: code_out/code_len/code_err are a new letter
//  code_err     out  1  letter overflowed (>5 elements); qualified by code_valid
//  space_valid  out  1  one-CLK pulse: word gap detected
// BEHAVIOUR
//  - key_in passes through a 2-flop synchronizer (key_s); all decisions use key_s.
//  - Reset: FSM=IDLE, run_cnt=0, accum code/len/err=0.
//    All outputs are 0: code_out, code_len, code_valid, code_err, space_valid.
//    Async assert; a partial letter is discarded with no pulse.
//  - When tick=0, state, counters and outputs hold; code_valid/space_valid are forced 0.
//  - FSM (evaluated on tick cycles only):
//    IDLE : key_s=1 -> MARK, run_cnt=1; else stay.
//    MARK : key_s=1 -> run_cnt+1 (saturating).
//           key_s=0 -> classify (run_cnt<=DOT_MAX ? dot : dash).
//             If len<5: write the bit at code[len], then len+1.
//             Else: set err; the element is dropped and len stays 5.
//             Then GAP, run_cnt=1.
//    GAP  : key_s=1 -> MARK, run_cnt=1 (intra-letter gap).
//           key_s=0 -> run_cnt+1.
//             When the new value == LETTER_GAP: load code_out/code_len/code_err from
//             the accumulators, pulse code_valid, clear the accumulators, go WORD.
//    WORD : key_s=1 -> MARK, run_cnt=1 (new letter, no space).
//           key_s=0 -> run_cnt+1.
//             When the new value == WORD_GAP: pulse space_valid, go IDLE.
//  - Pulse timing: code_valid and space_valid are registered. Each is high for exactly
//    the CLK cycle following the tick that reaches the threshold.
//  - code_out/code_len/code_err hold their value until the next code_valid.
//  - Mark run saturating at max: still classified as a dash; no error.
//  - Space exactly LETTER_GAP-1 ticks: the next mark continues the same letter.
//  - Boundary ties: mark == DOT_MAX is a dot; space == LETTER_GAP emits the letter.
//  - space_valid never pulses without a preceding code_valid.
//  - Leading space in IDLE generates nothing.
//  - Latency, key edge to FSM: 2 CLK synchronizer, plus wait for the next tick.
// STRUCTURE
//  - morse_pkg: FSM state localparams (IDLE/MARK/GAP/WORD, 2-bit), MAX_SYMS=5,
//    ELEM_DOT=0, ELEM_DASH=1.
//  - Sub-module sync_2ff: 2-flop synchronizer, async active-high reset to 0.
//  - Remaining logic (run counter, element accumulator, FSM, output registers) is
//    a single module.
// TESTING  (DOT_MAX=2, LETTER_GAP=5, WORD_GAP=10, tick=1 every CLK unless stated)
//  1 "A": mark 1, space 1, mark 4, space 5
//    -> one code_valid; code_out=5'b00010, code_len=2, code_err=0.
//  2 "E"+word: mark 2, space 10
//    -> code_valid (code_out=0, code_len=1).
//    -> space_valid exactly 5 ticks later; FSM in IDLE.
//  3 Overflow: six dots separated by 1-tick spaces, then space 5
//    -> code_valid with code_len=5, code_out=0, code_err=1.
//  4 Thresholds: mark 2 -> dot, mark 3 -> dash.
//    Space 4 -> same letter; space 5 -> letter emitted. Use a mark 2/space 4/mark 3/
//    space 5 sequence -> code_out=5'b00010, code_len=2.
//  5 Reset mid-letter: 3 elements, then pulse RST asynchronously
//    -> all outputs 0 immediately, no code_valid.
//    Then mark 3, space 5 -> code_out=5'b00001, code_len=1.
//  6 Tick gating: tick every 4th CLK, repeat test 1 with runs measured in ticks
//    -> identical results.
//    Also: code_valid is 1 CLK wide, and no state change occurs on non-tick cycles.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse symbol decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMark = 2'd1,
        StGap  = 2'd2,
        StWord = 2'd3
    } state_e;

    localparam int unsigned MAX_SYMS  = 5;
    localparam logic        ELEM_DOT  = 1'b0;
    localparam logic        ELEM_DASH = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/morse_symbol_decoder.sv
// Measures mark/space run lengths of a serial key, assembles dot/dash elements into
// letters and flags letter and word boundaries.
module morse_symbol_decoder
    import morse_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DOT_MAX    = 2,
    parameter int unsigned LETTER_GAP = 5,
    parameter int unsigned WORD_GAP   = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tick,
    input  logic       key_in,
    output logic [4:0] code_out,
    output logic [2:0] code_len,
    output logic       code_valid,
    output logic       code_err,
    output logic       space_valid
);

    if (!(DOT_MAX >= 1 && DOT_MAX < LETTER_GAP && LETTER_GAP < WORD_GAP &&
          WORD_GAP <= (2 ** CNT_W) - 1)) begin : gen_param_check
        $error("morse_symbol_decoder: illegal DOT_MAX/LETTER_GAP/WORD_GAP/CNT_W");
    end

    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] DotMax    = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] LetterGap = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] WordGap   = CNT_W'(WORD_GAP);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [2:0]       MaxLen    = 3'(MAX_SYMS);

    logic key_s;

    sync_2ff u_sync_key (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (key_in),
        .q_o   (key_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [4:0]       acc_code_q, acc_code_d;
    logic [2:0]       acc_len_q, acc_len_d;
    logic             acc_err_q, acc_err_d;
    logic [4:0]       code_out_q, code_out_d;
    logic [2:0]       code_len_q, code_len_d;
    logic             code_err_q, code_err_d;
    logic             code_valid_q, code_valid_d;
    logic             space_valid_q, space_valid_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             elem;

    assign cnt_inc = (run_cnt_q == CntMax) ? run_cnt_q : run_cnt_q + CntOne;
    // A saturated mark is simply a long dash.
    assign elem    = (run_cnt_q <= DotMax) ? ELEM_DOT : ELEM_DASH;

    always_comb begin
        state_d       = state_q;
        run_cnt_d     = run_cnt_q;
        acc_code_d    = acc_code_q;
        acc_len_d     = acc_len_q;
        acc_err_d     = acc_err_q;
        code_out_d    = code_out_q;
        code_len_d    = code_len_q;
        code_err_d    = code_err_q;
        code_valid_d  = 1'b0;
        space_valid_d = 1'b0;

        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (key_s) begin
                        state_d   = StMark;
                        run_cnt_d = CntOne;
                    end
                end
                StMark: begin
                    if (key_s) begin
                        run_cnt_d = cnt_inc;
                    end else begin
                        if (acc_len_q < MaxLen) begin
                            acc_code_d[acc_len_q] = elem;
                            acc_len_d             = acc_len_q + 3'd1;
                        end else begin
                            acc_err_d = 1'b1;
                        end
                        state_d   = StGap;
                        run_cnt_d = CntOne;
                    end
                end
                StGap: begin
                    if (key_s) begin
                        state_d   = StMark;
                        run_cnt_d = CntOne;
                    end else begin
                        run_cnt_d = cnt_inc;
                        if (cnt_inc == LetterGap) begin
                            code_out_d   = acc_code_q;
                            code_len_d   = acc_len_q;
                            code_err_d   = acc_err_q;
                            code_valid_d = 1'b1;
                            acc_code_d   = '0;
                            acc_len_d    = '0;
                            acc_err_d    = 1'b0;
                            state_d      = StWord;
                        end
                    end
                end
                StWord: begin
                    if (key_s) begin
                        state_d   = StMark;
                        run_cnt_d = CntOne;
                    end else begin
                        // Keeps counting from the mark end, so WORD_GAP is total space.
                        run_cnt_d = cnt_inc;
                        if (cnt_inc == WordGap) begin
                            space_valid_d = 1'b1;
                            state_d       = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= StIdle;
            run_cnt_q     <= '0;
            acc_code_q    <= '0;
            acc_len_q     <= '0;
            acc_err_q     <= 1'b0;
            code_out_q    <= '0;
            code_len_q    <= '0;
            code_err_q    <= 1'b0;
            code_valid_q  <= 1'b0;
            space_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_cnt_q     <= run_cnt_d;
            acc_code_q    <= acc_code_d;
            acc_len_q     <= acc_len_d;
            acc_err_q     <= acc_err_d;
            code_out_q    <= code_out_d;
            code_len_q    <= code_len_d;
            code_err_q    <= code_err_d;
            code_valid_q  <= code_valid_d;
            space_valid_q <= space_valid_d;
        end
    end

    assign code_out    = code_out_q;
    assign code_len    = code_len_q;
    assign code_err    = code_err_q;
    assign code_valid  = code_valid_q;
    assign space_valid = space_valid_q;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Scoreboard bench: stimulus pushes expected letters/word gaps, a monitor pops on pulses.
module tb_morse_symbol_decoder;

    typedef struct {
        logic       is_space;
        logic [4:0] code;
        logic [2:0] len;
        logic       err;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       tick = 1'b1;
    logic       key_in = 1'b0;
    logic [4:0] code_out;
    logic [2:0] code_len;
    logic       code_valid;
    logic       code_err;
    logic       space_valid;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   tick_period = 1;
    int   tdiv = 0;
    int   cyc = 0;
    int   cv_cyc = 0;
    logic last_tick = 1'b0;
    logic prev_cv = 1'b0;
    logic prev_sv = 1'b0;

    morse_symbol_decoder dut (
        .CLK         (CLK),
        .RST         (RST),
        .tick        (tick),
        .key_in      (key_in),
        .code_out    (code_out),
        .code_len    (code_len),
        .code_valid  (code_valid),
        .code_err    (code_err),
        .space_valid (space_valid)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc       <= cyc + 1;
        last_tick <= tick;
    end

    initial begin
        forever begin
            @(negedge CLK);
            tdiv = (tdiv + 1) % tick_period;
            tick = (tdiv == 0);
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic push_letter(input logic [4:0] code, input logic [2:0] len, input logic err);
        exp_t e;
        e.is_space = 1'b0;
        e.code     = code;
        e.len      = len;
        e.err      = err;
        sb.push_back(e);
    endtask

    task automatic push_space();
        exp_t e;
        e.is_space = 1'b1;
        e.code     = '0;
        e.len      = '0;
        e.err      = 1'b0;
        sb.push_back(e);
    endtask

    // Hold the key level for n tick cycles.
    task automatic drive(input logic lvl, input int n);
        int c;
        key_in = lvl;
        c = 0;
        while (c < n) begin
            @(posedge CLK);
            if (tick) c++;
        end
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_code_out"}, int'(code_out), 0);
        check({tag, "_code_len"}, int'(code_len), 0);
        check({tag, "_code_valid"}, int'(code_valid), 0);
        check({tag, "_code_err"}, int'(code_err), 0);
        check({tag, "_space_valid"}, int'(space_valid), 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && (code_valid || space_valid)) begin
                check("pulse_after_tick", int'(last_tick), 1);
                if (code_valid) check("code_valid_width", int'(prev_cv), 0);
                if (space_valid) check("space_valid_width", int'(prev_sv), 0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind_space", int'(space_valid), int'(e.is_space));
                    check("pulse_kind_code", int'(code_valid), int'(!e.is_space));
                    if (code_valid) begin
                        cv_cyc = cyc;
                        check("code_out", int'(code_out), int'(e.code));
                        check("code_len", int'(code_len), int'(e.len));
                        check("code_err", int'(code_err), int'(e.err));
                    end
                    if (space_valid && tick_period == 1)
                        check("space_delay_cycles", cyc - cv_cyc, 5);
                end
            end
            prev_cv = code_valid;
            prev_sv = space_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        repeat (3) @(posedge CLK);
        #2;
        check_outputs_zero("reset");
        RST = 1'b0;

        // Leading space in IDLE must produce nothing.
        drive(1'b0, 15);

        // A: .-
        push_letter(5'b00010, 3'd2, 1'b0);
        push_space();
        drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 4); drive(1'b0, 12);

        // E followed by word gap, space exactly 10
        push_letter(5'b00000, 3'd1, 1'b0);
        push_space();
        drive(1'b1, 2); drive(1'b0, 10); drive(1'b0, 3);

        // Overflow: six dots
        push_letter(5'b00000, 3'd5, 1'b1);
        push_space();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1);
            if (i < 5) drive(1'b0, 1);
        end
        drive(1'b0, 12);

        // Thresholds: mark 2 dot, space 4 continues, mark 3 dash
        push_letter(5'b00010, 3'd2, 1'b0);
        push_space();
        drive(1'b1, 2); drive(1'b0, 4); drive(1'b1, 3); drive(1'b0, 12);

        // Reset mid-letter: partial letter discarded
        drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 3); drive(1'b0, 1); drive(1'b1, 1);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        key_in = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(1'b0, 3);
        push_letter(5'b00001, 3'd1, 1'b0);
        push_space();
        drive(1'b1, 3); drive(1'b0, 12);

        // Tick every 4th clock: repeat A
        tick_period = 4;
        drive(1'b0, 2);
        push_letter(5'b00010, 3'd2, 1'b0);
        push_space();
        drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 4); drive(1'b0, 12);

        budget = 0;
        while (sb.size() != 0 && budget < 400) begin
            @(posedge CLK);
            budget++;
        end
        repeat (4) @(posedge CLK);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
